// File: rtl/fifo_ram.sv
// Simple dual-port memory: one write port, one registered read port.
// Contents are not reset so the array can map onto block or distributed RAM.
module fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read-before-write: a read and write of one address on the same edge returns the old word.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/push_to_axis_fifo.sv
// Elastic buffer from a push/almost-full producer to a valid/ready consumer.
// Capacity is the RAM plus one output word; dropped pushes raise a sticky overflow flag.
module push_to_axis_fifo #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  iwrite,
  output logic                  oafull,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  input  logic                  iready,
  output logic                  ooverflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP    = CW'((1 << ADDR_WIDTH) + 1);
  localparam logic [CW-1:0] MARGIN = CW'(AFULL_MARGIN);

  logic [CW-1:0]         count, count_next, mem_count, free_next;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  pop, accept, mem_nonempty, load_slot, load_mem, load_byp, write_mem;
  logic                  sel_mem;
  logic [DATA_WIDTH-1:0] byp_data, ram_rdata;

  assign pop          = ovalid & iready;
  assign accept       = iwrite & ((count < CAP) | pop);
  assign mem_count    = count - CW'(ovalid);
  assign mem_nonempty = (mem_count != '0);
  assign load_slot    = ~ovalid | pop;
  assign load_mem     = load_slot & mem_nonempty;
  assign load_byp     = load_slot & ~mem_nonempty & accept;
  assign write_mem    = accept & ~load_byp;

  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + CW'(1);
    else if (pop && !accept) count_next = count - CW'(1);
  end

  assign free_next = CAP - count_next;

  fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (write_mem),
    .waddr(wr_ptr),
    .wdata(idata),
    .re   (load_mem),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  // The head word lives either in the RAM read register or in the bypass register.
  assign odata = sel_mem ? ram_rdata : byp_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovalid    <= 1'b0;
      oafull    <= 1'b0;
      ooverflow <= 1'b0;
      sel_mem   <= 1'b0;
      byp_data  <= '0;
    end else begin
      count  <= count_next;
      oafull <= (free_next <= MARGIN);
      if (write_mem) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (load_mem)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (load_mem || load_byp) ovalid <= 1'b1;
      else if (pop)             ovalid <= 1'b0;
      if (load_mem) begin
        sel_mem <= 1'b1;
      end else if (load_byp) begin
        sel_mem  <= 1'b0;
        byp_data <= idata;
      end
      if (iwrite && !accept) ooverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_push_to_axis_fifo.sv
// Scoreboard bench: the stimulus pushes accepted words into an expected queue, a monitor
// compares the head word, valid, almost-full and overflow against a queue-level model.
module tb_push_to_axis_fifo;

  localparam int CAP = 17;
  localparam int AFM = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       iwrite = 1'b0;
  logic       iready = 1'b0;
  logic       oafull, ovalid, ooverflow;
  logic [7:0] odata;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         mcount = 0;
  logic       mover = 1'b0;

  push_to_axis_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AFULL_MARGIN(AFM)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .idata    (idata),
    .iwrite   (iwrite),
    .oafull   (oafull),
    .odata    (odata),
    .ovalid   (ovalid),
    .iready   (iready),
    .ooverflow(ooverflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model follows the FIFO rules on occupancy alone.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic p, acc;
    iwrite = w;
    idata  = d;
    iready = r;
    p   = (mcount > 0) && r;
    acc = w && ((mcount < CAP) || p);
    @(posedge clock);
    if (acc) exp_q.push_back(d);
    if (acc && !p) mcount++;
    else if (p && !acc) mcount--;
    if (w && !acc) mover = 1'b1;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      chk("ovalid", 32'(ovalid), 32'(mcount > 0));
      chk("oafull", 32'(oafull), 32'((CAP - mcount) <= AFM));
      chk("ooverflow", 32'(ooverflow), 32'(mover));
      if (ovalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL odata_unexpected actual=%0h expected=none at %0t", odata, $time);
        end else begin
          chk("odata", 32'(odata), 32'(exp_q[0]));
          if (iready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with iwrite toggling
    for (int i = 0; i < 4; i++) begin
      iwrite = ~iwrite;
      idata  = 8'(i + 8'h30);
      @(posedge clock);
      #1;
      chk("rst_ovalid", 32'(ovalid), 32'd0);
      chk("rst_odata", 32'(odata), 32'd0);
      chk("rst_oafull", 32'(oafull), 32'd0);
      chk("rst_overflow", 32'(ooverflow), 32'd0);
    end
    iwrite = 1'b0;
    resetn = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    chk("first_ovalid", 32'(ovalid), 32'd1);
    chk("first_odata", 32'(odata), 32'hA5);
    drain(2);

    // Fill to capacity in order, then drain
    for (int i = 0; i < CAP; i++) step(1'b1, 8'(i), 1'b0);
    chk("full_oafull", 32'(oafull), 32'd1);
    drain(CAP + 1);
    chk("order_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: dropped words never appear, flag is sticky
    for (int i = 0; i < CAP; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(ooverflow), 32'd1);
    drain(CAP + 1);
    chk("ovf_sticky", 32'(ooverflow), 32'd1);

    // Asynchronous reset in the middle of a partial fill
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_ovalid", 32'(ovalid), 32'd0);
    chk("arst_odata", 32'(odata), 32'd0);
    chk("arst_oafull", 32'(oafull), 32'd0);
    chk("arst_overflow", 32'(ooverflow), 32'd0);
    exp_q.delete();
    mcount = 0;
    mover  = 1'b0;
    iwrite = 1'b1;
    @(posedge clock);
    #1 resetn = 1'b1;
    iwrite = 1'b0;

    // Full with simultaneous push and pop
    for (int i = 0; i < CAP; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    chk("fullpp_count", 32'(mcount), 32'(CAP));
    chk("fullpp_overflow", 32'(ooverflow), 32'd0);
    drain(CAP + 1);

    // Streaming one in, one out per cycle
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b1);
    chk("stream_count", 32'(mcount), 32'd1);
    drain(2);

    // Random traffic
    for (int i = 0; i < 1000; i++)
      step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
    drain(CAP + 2);
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    chk("final_ovalid", 32'(ovalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_to_axis_fifo.md
# push_to_axis_fifo

Elastic buffer between the UART receive path's push-style output (data + write strobe, almost-full back-pressure) and a downstream AXI-Stream-style consumer (valid/ready). It absorbs bursts arriving at up to 12 Mbaud while the consumer stalls. It drives the receiver's almost-full input so RTS is dropped early enough. Overrun is flagged rather than silently lost.

## Interface
- ADDR_WIDTH, 4: memory holds 2**ADDR_WIDTH words; total capacity CAP = 2**ADDR_WIDTH + 1 (memory + output register).
- DATA_WIDTH, 8: word width.
- AFULL_MARGIN, 4: oafull asserts when free slots ≤ AFULL_MARGIN; legal range 1..CAP-1.

- clock  in  1  single clock; all logic on posedge.
- resetn  in  1  reset; asynchronous, active-low.
- idata  in  DATA_WIDTH  push data, sampled when iwrite=1.
- iwrite  in  1  push strobe, one word per high cycle; no ready return.
- oafull  out  1  almost-full, registered.
- odata  out  DATA_WIDTH  head word, registered.
- ovalid  out  1  odata valid, registered.
- iready  in  1  consumer ready; transfer when ovalid && iready.
- ooverflow  out  1  sticky: a push was dropped.

## Operation
- Occupancy count: ADDR_WIDTH+1 bits, range 0..CAP; includes the output register.
- pop = ovalid && iready.
- A push is accepted when iwrite && (count < CAP || pop).
- Any other push is dropped:
  - memory and pointers unchanged;
  - ooverflow set to 1 and held until reset.
- Count update:
  - +1 on accepted push without pop;
  - -1 on pop without push;
  - unchanged otherwise.
- Output register loading, priority order:
  - if the output register is empty, or pop occurs, and memory is non-empty: load the memory word at the read pointer; advance the read pointer;
  - else if the output register is empty or pop occurs, memory is empty, and a push is accepted: load idata directly (bypass, memory untouched);
  - else if pop occurs: ovalid=0.
- A push that does not bypass is written to memory at the write pointer; the write pointer advances.
- Pointers are ADDR_WIDTH bits and wrap naturally modulo 2**ADDR_WIDTH.
- Strict FIFO order in all cases, including bypass.
- oafull is registered from the next-state count: oafull <= (CAP - count_next) ≤ AFULL_MARGIN.
- odata holds its value while ovalid && !iready (AXI stability); odata is don't-care when ovalid=0.

## Timing
- Reset values:
  - ovalid=0, odata=0, oafull=0, ooverflow=0;
  - count=0, both pointers=0.
- Latency into an empty FIFO: iwrite at edge N → ovalid=1 with that word after edge N.
- Sustained: one push and one pop per cycle indefinitely at any occupancy 1..CAP without loss.
- oafull reflects pushes and pops of the previous edge; it has no combinational path from iwrite or iready.
- Memory read is synchronous; a word written to memory at edge N is readable by the output load at edge N+1 or later.
  - Bypass covers the empty-memory case.
  - Write-then-read of the same address in one cycle never occurs.
- Reset assertion mid-stream:
  - all stored words are discarded;
  - outputs go to their reset values immediately, asynchronously.
- Release of resetn is synchronised upstream; the block relies on that.

## Structure
- Sub-module fifo_ram: simple dual-port memory.
  - 2**ADDR_WIDTH × DATA_WIDTH.
  - One write port, one registered read port.
  - No reset on contents, so it maps to MachXO2 EBR/distributed RAM.
- Top holds pointers, count, output register, and flags.
- No shared package.
  - CAP and the free-slot computation are localparams/wires inside the module.
  - The push-interface signal set (idata/iwrite/oafull) matches the receiver's (odata/owrite/oafull) by port naming only.

## Test plan
- Reset: hold resetn=0 with iwrite toggling → all outputs 0. Release, push 0xA5 → ovalid=1, odata=0xA5 one cycle later.
- Order: iready=0, push 0x00..0x10 (17 words, CAP=17) → oafull=1 once count ≥13, no overflow. Then iready=1 → 0x00..0x10 emerge in order, ovalid=0 after the last word.
- Overflow: fill to 17, push 0xEE with iready=0 → word dropped, ooverflow=1 and sticky. Drained sequence contains no 0xEE.
- Full + simultaneous push/pop: at count=17, push 0x55 while popping → accepted, count stays 17, ooverflow stays 0. 0x55 is last out.
- Streaming: iwrite=1, iready=1 every cycle for 100 cycles with an incrementing pattern → output equals input delayed by 1 cycle, count ≤1.
- Wrap + random: 1000 pushes with random iwrite/iready at 50% → scoreboard match, pointers wrap many times. oafull matches the reference model's count every cycle.
